// File: rtl/ch4_noise_gen_pkg.sv
// Shared constants and register-field views for the channel-4 noise voice.
package apu_ch4_pkg;

    localparam logic [14:0] LFSR_SEED = 15'h7FFF;
    localparam logic [3:0]  VOL_MAX   = 4'hF;

    typedef struct packed {
        logic [3:0] shift;
        logic       width;
        logic [2:0] divisor;
    } ch4_nr43_t;

    typedef struct packed {
        logic [3:0] vol;
        logic       dir;
        logic [2:0] period;
    } ch4_nr42_t;

endpackage

// File: rtl/ch4_noise_gen_if.sv
// Decoded register-block fields and trigger/expiry strobes for channel 4.
interface ch4_noise_gen_if;

    logic       ch4_restart;
    logic [7:0] ff21_d;
    logic [7:0] ff22_d;
    logic       ff23_d6;
    logic       fugo_q;

    modport master (
        output ch4_restart,
        output ff21_d,
        output ff22_d,
        output ff23_d6,
        output fugo_q
    );

    modport slave (
        input ch4_restart,
        input ff21_d,
        input ff22_d,
        input ff23_d6,
        input fugo_q
    );

endinterface

// File: rtl/ch4_noise_gen_envelope.sv
// Channel-4 volume envelope: volume register, period counter, saturation.
module ch4_envelope
    import apu_ch4_pkg::*;
#(
    parameter int VOL_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             env_tick_i,
    ch4_noise_gen_if.slave   bus,
    output logic [VOL_W-1:0] vol_o
);

    ch4_nr42_t        nr42;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             at_max, at_min;

    assign nr42   = bus.ff21_d;
    assign at_max = (vol_q == VOL_W'(VOL_MAX));
    assign at_min = (vol_q == '0);
    assign vol_o  = vol_q;

    always_comb begin
        vol_d = vol_q;
        cnt_d = cnt_q;
        if (bus.ch4_restart) begin
            vol_d = VOL_W'(nr42.vol);
            cnt_d = nr42.period;
        end else if (env_tick_i && nr42.period != 3'd0) begin
            // A counter of 0 (post reset) expires on the first tick too
            if (cnt_q <= 3'd1) begin
                cnt_d = nr42.period;
                if (nr42.dir && !at_max) begin
                    vol_d = vol_q + 1'b1;
                end else if (!nr42.dir && !at_min) begin
                    vol_d = vol_q - 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vol_q <= '0;
            cnt_q <= '0;
        end else begin
            vol_q <= vol_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ch4_noise_gen.sv
// Channel-4 noise voice: divider, 15/7-bit LFSR, envelope, active flag.
// CH4_DEBUG_PORTS_EN adds lfsr_q, vol_q and lfsr_clk_pulse outputs.
module ch4_noise_gen
    import apu_ch4_pkg::*;
#(
    parameter int LFSR_W      = 15,
    parameter int VOL_W       = 4,
    parameter int SHIFT_CNT_W = 14
) (
    input  logic             clk,
    input  logic             apu_reset,
    input  logic             tick_1m,
    input  logic             env_tick_64hz,
    input  logic             ch4_restart,
    input  logic [7:0]       ff21_d,
    input  logic [7:0]       ff22_d,
    input  logic             ff23_d6,
    input  logic             fugo_q,
    output logic [VOL_W-1:0] ch4_amp,
    output logic             ch4_active,
    output logic             ch4_dac_en
`ifdef CH4_DEBUG_PORTS_EN
    ,
    output logic [14:0]      lfsr_q,
    output logic [3:0]       vol_q,
    output logic             lfsr_clk_pulse
`endif
);

    ch4_noise_gen_if u_bus ();

    assign u_bus.ch4_restart = ch4_restart;
    assign u_bus.ff21_d      = ff21_d;
    assign u_bus.ff22_d      = ff22_d;
    assign u_bus.ff23_d6     = ff23_d6;
    assign u_bus.fugo_q      = fugo_q;

    ch4_nr43_t              nr43;
    logic [3:0]             div_q, div_d;
    logic [3:0]             div_rld;
    logic [SHIFT_CNT_W-1:0] pre_q, pre_d, pre_inc;
    logic [15:0]            pre_fall;
    logic [LFSR_W-1:0]      sr_q, sr_d, sr_next;
    logic                   fb;
    logic                   lfsr_step;
    logic                   act_q, act_d;
    logic                   fugo_prev_q;
    logic                   fugo_rise;
    logic [VOL_W-1:0]       amp_q, amp_d;
    logic [VOL_W-1:0]       env_vol;

    assign nr43       = u_bus.ff22_d;
    assign ch4_dac_en = |u_bus.ff21_d[7:3];
    assign ch4_active = act_q & ch4_dac_en;
    assign ch4_amp    = amp_q;
    assign fugo_rise  = u_bus.fugo_q & ~fugo_prev_q;

    // Base period is 2*r ticks, r = 0 counts as one tick
    assign div_rld  = (nr43.divisor == 3'd0) ? 4'd0
                    : {nr43.divisor, 1'b0} - 4'd1;
    assign pre_inc  = pre_q + 1'b1;
    assign pre_fall = 16'(pre_q & ~pre_inc);

    assign fb = sr_q[0] ^ sr_q[1];

    always_comb begin
        sr_next = {fb, sr_q[LFSR_W-1:1]};
        if (nr43.width) begin
            sr_next[6] = fb;
        end
    end

    always_comb begin
        div_d     = div_q;
        pre_d     = pre_q;
        sr_d      = sr_q;
        lfsr_step = 1'b0;
        if (u_bus.ch4_restart) begin
            div_d = div_rld;
            pre_d = '0;
            sr_d  = LFSR_W'(LFSR_SEED);
        end else if (tick_1m) begin
            if (div_q == 4'd0) begin
                div_d = div_rld;
                pre_d = pre_inc;
                // Shift values past the prescaler width never fall
                lfsr_step = pre_fall[nr43.shift];
                if (lfsr_step) begin
                    sr_d = sr_next;
                end
            end else begin
                div_d = div_q - 4'd1;
            end
        end
    end

    always_comb begin
        priority case (1'b1)
            u_bus.ch4_restart:           act_d = ch4_dac_en;
            !ch4_dac_en:                 act_d = 1'b0;
            fugo_rise && u_bus.ff23_d6:  act_d = 1'b0;
            default:                     act_d = act_q;
        endcase
    end

    always_comb begin
        amp_d = '0;
        if (ch4_active && !sr_q[0]) begin
            amp_d = env_vol;
        end
    end

    always_ff @(posedge clk) begin
        if (apu_reset) begin
            div_q       <= '0;
            pre_q       <= '0;
            sr_q        <= LFSR_W'(LFSR_SEED);
            act_q       <= 1'b0;
            fugo_prev_q <= 1'b0;
            amp_q       <= '0;
        end else begin
            div_q       <= div_d;
            pre_q       <= pre_d;
            sr_q        <= sr_d;
            act_q       <= act_d;
            fugo_prev_q <= u_bus.fugo_q;
            amp_q       <= amp_d;
        end
    end

    ch4_envelope #(
        .VOL_W(VOL_W)
    ) u_env (
        .clk_i      (clk),
        .rst_i      (apu_reset),
        .env_tick_i (env_tick_64hz),
        .bus        (u_bus.slave),
        .vol_o      (env_vol)
    );

`ifdef CH4_DEBUG_PORTS_EN
    assign lfsr_q         = 15'(sr_q);
    assign vol_q          = 4'(env_vol);
    assign lfsr_clk_pulse = lfsr_step;
`endif

endmodule
